// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: per-stage stall/bubble control and
// registered per-source forwarding selects. Define HAZARD_WB_CAPTURE_EN to capture WB data instead of stalling.
module pipe_hazard_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned NSRC   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC*RA_W-1:0]     id_rs,
  input  logic [NSRC-1:0]          id_rs_used,
  input  logic [RA_W-1:0]          ex_rd,
  input  logic [RA_W-1:0]          mem_rd,
  input  logic [RA_W-1:0]          wb_rd,
  input  logic                     ex_we,
  input  logic                     mem_we,
  input  logic                     wb_we,
  input  logic                     ex_is_load,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     iready_n,
  input  logic                     dready_n,
  input  logic                     dbusy,
  input  logic                     mem_rd_req,
  input  logic                     mem_wr_req,
  input  logic                     br_taken_ex,
  input  logic                     br_taken_id,
  output logic [NSRC*2-1:0]        fwd_sel,
  output logic [NSRC*DATA_W-1:0]   cap_data,
  output logic                     stall_id,
  output logic                     stall_ex,
  output logic                     stall_mem,
  output logic                     stall_wb,
  output logic                     nop_if,
  output logic                     nop_id,
  output logic                     nop_ex
);

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10,
    SEL_CAP   = 2'b11
  } fwd_sel_e;

  logic [NSRC-1:0]        m_ex, m_mem, m_wb;
  logic                   mem_stall, load_use, wb_hz, use_stall;
  logic                   advance, flush;
  logic [NSRC*2-1:0]      fwd_sel_d, fwd_sel_q;

  always_comb begin
    m_ex  = '0;
    m_mem = '0;
    m_wb  = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      m_ex[i]  = id_rs_used[i] & ex_we  & (ex_rd  != '0) & (ex_rd  == id_rs[i*RA_W +: RA_W]);
      m_mem[i] = id_rs_used[i] & mem_we & (mem_rd != '0) & (mem_rd == id_rs[i*RA_W +: RA_W]);
      m_wb[i]  = id_rs_used[i] & wb_we  & (wb_rd  != '0) & (wb_rd  == id_rs[i*RA_W +: RA_W]);
    end
  end

  assign mem_stall = iready_n | (dready_n & mem_rd_req) | (dbusy & mem_wr_req);
  assign load_use  = (|m_ex) & ex_is_load;

`ifdef HAZARD_WB_CAPTURE_EN
  assign wb_hz = 1'b0;
`else
  // Without capture, a WB-only producer costs one bubble; afterwards the regfile holds the value.
  assign wb_hz = |(m_wb & ~m_ex & ~m_mem);
`endif

  assign use_stall = load_use | wb_hz;
  assign advance   = ~mem_stall & ~br_taken_ex & ~use_stall;
  assign flush     = ~mem_stall & (br_taken_ex | use_stall);

  always_comb begin
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    stall_wb  = 1'b0;
    nop_if    = 1'b0;
    nop_id    = 1'b0;
    nop_ex    = 1'b0;
    if (mem_stall) begin
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      stall_wb  = 1'b1;
    end else if (br_taken_ex) begin
      nop_if = 1'b1;
      nop_id = 1'b1;
      nop_ex = 1'b1;
    end else begin
      if (use_stall) begin
        stall_id = 1'b1;
        nop_if   = 1'b1;
        nop_ex   = 1'b1;
      end
      if (br_taken_id) nop_if = 1'b1;
    end
  end

`ifdef HAZARD_WB_CAPTURE_EN
  logic [NSRC*DATA_W-1:0] cap_data_d, cap_data_q;
`endif

  always_comb begin
    fwd_sel_d = fwd_sel_q;
`ifdef HAZARD_WB_CAPTURE_EN
    cap_data_d = cap_data_q;
`endif
    if (flush) begin
      fwd_sel_d = '0;
    end else if (advance) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        // A load EX match cannot reach here: it raises load_use and blocks advance.
        if (m_ex[i]) begin
          fwd_sel_d[2*i +: 2] = SEL_EXMEM;
        end else if (m_mem[i]) begin
          fwd_sel_d[2*i +: 2] = SEL_MEMWB;
        end else if (m_wb[i]) begin
`ifdef HAZARD_WB_CAPTURE_EN
          fwd_sel_d[2*i +: 2]          = SEL_CAP;
          cap_data_d[i*DATA_W +: DATA_W] = wb_data;
`else
          fwd_sel_d[2*i +: 2] = SEL_RF;
`endif
        end else begin
          fwd_sel_d[2*i +: 2] = SEL_RF;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fwd_sel_q <= '0;
    else      fwd_sel_q <= fwd_sel_d;
  end

  assign fwd_sel = fwd_sel_q;

`ifdef HAZARD_WB_CAPTURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cap_data_q <= '0;
    else      cap_data_q <= cap_data_d;
  end

  assign cap_data = cap_data_q;
`else
  logic wb_data_unused;
  assign wb_data_unused = ^wb_data;
  assign cap_data       = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It supports NSRC source operands per instruction. It decides per-stage stall and nop (bubble/flush) and registers a per-source forwarding select into the ID→EX boundary. It also captures WB-stage write data for operands whose producer retires while the consumer waits in ID, so the register file needs no write-through. It replaces the fixed 2-source noper block.

## Interface
- DATA_W, 32, operand/result width
- RA_W, 5, register address width
- NSRC, 2, source operands per instruction (1..3)
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs  in  NSRC*RA_W  source register addresses of ID instruction; source i at [i*RA_W +: RA_W]
- id_rs_used  in  NSRC  source i is actually read
- ex_rd, mem_rd, wb_rd  in  RA_W each  destination of EX, MEM, WB instruction
- ex_we, mem_we, wb_we  in  1 each  stage instruction writes a register
- ex_is_load  in  1  EX instruction is a load
- wb_data  in  DATA_W  value being written back this cycle
- iready_n, dready_n, dbusy  in  1 each  cache handshakes (low = ready / not busy)
- mem_rd_req, mem_wr_req  in  1 each  MEM stage load / store
- br_taken_ex  in  1  branch/jump resolved taken in EX
- br_taken_id  in  1  early branch resolved taken in ID
- fwd_sel  out  NSRC*2  registered select for EX: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data, 11 cap_data
- cap_data  out  NSRC*DATA_W  registered captured WB values
- stall_id, stall_ex, stall_mem, stall_wb  out  1 each  hold stage register
- nop_if, nop_id, nop_ex  out  1 each  load a bubble into that stage's output register

## Operation
- Source match rule: m_X[i] = id_rs_used[i] & X_we & (X_rd != 0) & (X_rd == id_rs[i]). Register 0 never matches.
- mem_stall = iready_n | (dready_n & mem_rd_req) | (dbusy & mem_wr_req).
- load_use = OR over i of (m_EX[i] & ex_is_load).
- Priority: mem_stall > br_taken_ex > load_use / br_taken_id.
- mem_stall: stall_id/ex/mem/wb = 1; all nop = 0; no internal register changes.
- br_taken_ex (no mem_stall): nop_if = nop_id = nop_ex = 1. The load_use stall is suppressed because the consumer is flushed.
- load_use (no mem_stall, no br_taken_ex): stall_id = 1 and nop_if = 1, which holds IF/ID. nop_ex = 1 inserts the bubble.
- br_taken_id: nop_if = 1.
- ID advances when none of mem_stall, load_use, br_taken_ex is active. On advance, per source i, the priority is EX > MEM > WB:
  - non-load m_EX: sel 01.
  - m_MEM: sel 10.
  - m_WB: sel 11 and cap_data[i] <= wb_data.
  - otherwise: sel 00.
- If ID does not advance, fwd_sel is not updated, except on a bubble or flush cycle, where fwd_sel <= 0.
- cap_data[i] holds its value unless reloaded.

## Timing
- Reset (rst low, asynchronous): fwd_sel = 0, cap_data = 0.
- stall_* and nop_* are combinational from current inputs, so they are valid in the same cycle. With all inputs idle they are 0.
- fwd_sel and cap_data are valid one cycle after the ID advance edge, i.e. during the consumer's EX cycle.
- Load-use costs exactly 1 bubble. On the following edge the load is in MEM and the consumer is still in ID, so it resolves to sel 10.
- Back-to-back load-use on a different source re-evaluates each cycle with no extra state.
- Reset mid-stall: all registered state clears immediately. Combinational outputs follow the inputs.

## Configuration
- HAZARD_WB_CAPTURE_EN defined: behaviour as above, with sel 11 and cap_data.
- HAZARD_WB_CAPTURE_EN undefined:
  - cap_data is tied to 0 and sel 11 is never produced.
  - An m_WB match without a higher-priority match asserts stall_id = 1, nop_if = 1, nop_ex = 1 for one cycle, the same as load_use.
  - After that cycle the value is in the regfile and the select is 00.

## Test plan
- Reset: rst low for 3 cycles with random inputs -> fwd_sel = 0 and cap_data = 0. After release with idle inputs, all stall/nop = 0.
- ALU chain: EX writes x5 (non-load), ID reads x5 on src0 -> no stall; next cycle fwd_sel[1:0] = 01. With mem_rd = x5 instead -> 10.
- Load-use: EX load to x7, ID src1 = x7 -> stall_id = nop_if = nop_ex = 1 for exactly one cycle; next cycle fwd_sel[3:2] = 10.
- WB capture (macro on): wb_rd = x9, wb_data = 0xDEADBEEF, ID src0 = x9, no other match -> fwd_sel[1:0] = 11 and cap_data[31:0] = 0xDEADBEEF. With macro off -> one-cycle stall, then sel 00.
- Priority: x3 matches EX (non-load) and MEM simultaneously -> sel 01. A match against x0 -> sel 00.
- Mem stall during load-use: dready_n = 1 with mem_rd_req = 1, for 4 cycles -> all stall_* = 1 and nop_* = 0, fwd_sel unchanged. Then br_taken_ex = 1 -> nop_if/id/ex = 1 and fwd_sel = 0.
